fp_mult_prenorm: RTL

Pre-normalisation and unpack stage for the single-precision floating-point multiplier datapath.
- Takes two IEEE-754 binary32 operands through a valid/ready handshake and classifies them.
- Left-normalises subnormal significands iteratively, one bit per cycle.
- Delivers sign, the biased 10-bit exponent sum and two 24-bit hidden-bit significands, which feed the mantissa multiplier and the post-multiply normaliser.
- Reports special operand classes so the downstream path can bypass them.

---
 rtl/fp_pkg.sv | 43 ++++
 rtl/fp_operand_classify.sv | 40 ++++
 rtl/fp_mult_prenorm.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the binary32 multiplier pre-normalisation stage:
// field widths and slice positions, class encodings, FSM state codes and
// the per-operand unpack record produced by the classifier.
package fp_pkg;

  localparam int unsigned BIAS        = 127;
  localparam int unsigned EXP_W       = 10;
  localparam int unsigned MAN_W       = 24;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned EXP_FIELD_W = 8;
  localparam int unsigned FRAC_W      = 23;

  // binary32 field slice positions
  localparam int unsigned SIGN_POS = 31;
  localparam int unsigned EXP_HI   = 30;
  localparam int unsigned EXP_LO   = 23;
  localparam int unsigned FRAC_HI  = 22;
  localparam int unsigned FRAC_LO  = 0;

  // operand / result class encodings
  localparam logic [1:0] CLS_NORMAL = 2'b00;
  localparam logic [1:0] CLS_ZERO   = 2'b01;
  localparam logic [1:0] CLS_INF    = 2'b10;
  localparam logic [1:0] CLS_NAN    = 2'b11;

  // FSM state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLASS = 3'd1;
  localparam logic [2:0] ST_NORM  = 3'd2;
  localparam logic [2:0] ST_EXP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Unpacked operand: sign, class, working exponent, hidden-bit significand,
  // and whether the significand still needs left-normalisation.
  typedef struct packed {
    logic             sign;
    logic [1:0]       cls;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] sig;
    logic             sub;
  } operand_t;

endpackage

// File: rtl/fp_operand_classify.sv
// Combinational unpack of one binary32 operand.
//   op     : binary32 operand
//   info_c : sign, class, working exponent (10-bit), 24-bit significand,
//            subnormal flag
module fp_operand_classify
  import fp_pkg::*;
(
  input  logic [WORD_W-1:0] op,
  output operand_t          info_c
);

  logic [EXP_FIELD_W-1:0] e;
  logic [FRAC_W-1:0]      f;

  assign e = op[EXP_HI:EXP_LO];
  assign f = op[FRAC_HI:FRAC_LO];

  // Specials carry zero exponent/significand; subnormals use exponent 1.
  always_comb begin
    info_c      = '0;
    info_c.sign = op[SIGN_POS];
    if (e == '0) begin
      if (f == '0) begin
        info_c.cls = CLS_ZERO;
      end else begin
        info_c.cls = CLS_NORMAL;
        info_c.sub = 1'b1;
        info_c.exp = EXP_W'(1);
        info_c.sig = {1'b0, f};
      end
    end else if (e == '1) begin
      info_c.cls = (f == '0) ? CLS_INF : CLS_NAN;
    end else begin
      info_c.cls = CLS_NORMAL;
      info_c.exp = EXP_W'(e);
      info_c.sig = {1'b1, f};
    end
  end

endmodule

// File: rtl/fp_mult_prenorm.sv
// Pre-normalisation / unpack stage of the binary32 multiplier.
//   clk, rst_n           : clock, async active-low reset
//   in_valid/in_ready    : operand pair handshake (ready only when idle)
//   a_in, b_in           : binary32 operands
//   out_valid/out_ready  : result handshake, outputs held while stalled
//   sign_out             : product sign
//   exp_out              : expA + expB - BIAS, 10-bit two's complement
//   frac_a_out/frac_b_out: normalised 24-bit significands
//   class_out            : 00 normal, 01 zero, 10 infinity, 11 NaN
module fp_mult_prenorm
  import fp_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_out,
  output logic [EXP_W-1:0]  exp_out,
  output logic [MAN_W-1:0]  frac_a_out,
  output logic [MAN_W-1:0]  frac_b_out,
  output logic [1:0]        class_out
);

  logic [2:0]        state, state_n;
  logic [WORD_W-1:0] a_q, a_n, b_q, b_n;
  logic [EXP_W-1:0]  exp_a, exp_a_n, exp_b, exp_b_n;
  logic [MAN_W-1:0]  sig_a, sig_a_n, sig_b, sig_b_n;
  logic              in_ready_n, out_valid_n, sign_n;
  logic [EXP_W-1:0]  exp_out_n;
  logic [MAN_W-1:0]  frac_a_n, frac_b_n;
  logic [1:0]        class_n;

  operand_t   info_a_c, info_b_c;
  logic [1:0] pair_cls_c;

  fp_operand_classify u_cls_a (.op(a_q), .info_c(info_a_c));
  fp_operand_classify u_cls_b (.op(b_q), .info_c(info_b_c));

  // Pair class priority: NaN (incl. inf x zero), then inf, then zero.
  always_comb begin
    pair_cls_c = CLS_NORMAL;
    if (info_a_c.cls == CLS_NAN || info_b_c.cls == CLS_NAN ||
        (info_a_c.cls == CLS_INF && info_b_c.cls == CLS_ZERO) ||
        (info_a_c.cls == CLS_ZERO && info_b_c.cls == CLS_INF)) begin
      pair_cls_c = CLS_NAN;
    end else if (info_a_c.cls == CLS_INF || info_b_c.cls == CLS_INF) begin
      pair_cls_c = CLS_INF;
    end else if (info_a_c.cls == CLS_ZERO || info_b_c.cls == CLS_ZERO) begin
      pair_cls_c = CLS_ZERO;
    end
  end

  // State register and all datapath/output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      exp_a      <= '0;
      exp_b      <= '0;
      sig_a      <= '0;
      sig_b      <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      sign_out   <= 1'b0;
      exp_out    <= '0;
      frac_a_out <= '0;
      frac_b_out <= '0;
      class_out  <= CLS_NORMAL;
    end else begin
      state      <= state_n;
      a_q        <= a_n;
      b_q        <= b_n;
      exp_a      <= exp_a_n;
      exp_b      <= exp_b_n;
      sig_a      <= sig_a_n;
      sig_b      <= sig_b_n;
      in_ready   <= in_ready_n;
      out_valid  <= out_valid_n;
      sign_out   <= sign_n;
      exp_out    <= exp_out_n;
      frac_a_out <= frac_a_n;
      frac_b_out <= frac_b_n;
      class_out  <= class_n;
    end
  end

  // Next-state and next-value logic.
  always_comb begin
    state_n     = state;
    a_n         = a_q;
    b_n         = b_q;
    exp_a_n     = exp_a;
    exp_b_n     = exp_b;
    sig_a_n     = sig_a;
    sig_b_n     = sig_b;
    out_valid_n = out_valid;
    sign_n      = sign_out;
    exp_out_n   = exp_out;
    frac_a_n    = frac_a_out;
    frac_b_n    = frac_b_out;
    class_n     = class_out;

    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          a_n     = a_in;
          b_n     = b_in;
          state_n = ST_CLASS;
        end
      end
      ST_CLASS: begin
        sign_n  = info_a_c.sign ^ info_b_c.sign;
        exp_a_n = info_a_c.exp;
        exp_b_n = info_b_c.exp;
        sig_a_n = info_a_c.sig;
        sig_b_n = info_b_c.sig;
        class_n = pair_cls_c;
        if (pair_cls_c != CLS_NORMAL) begin
          exp_out_n = '0;
          frac_a_n  = '0;
          frac_b_n  = '0;
          state_n   = ST_DONE;
        end else if (info_a_c.sub || info_b_c.sub) begin
          state_n = ST_NORM;
        end else begin
          state_n = ST_EXP;
        end
      end
      ST_NORM: begin
        // Operands already normalised simply hold; the other keeps shifting.
        if (!sig_a[MAN_W-1]) begin
          sig_a_n = {sig_a[MAN_W-2:0], 1'b0};
          exp_a_n = exp_a - EXP_W'(1);
        end
        if (!sig_b[MAN_W-1]) begin
          sig_b_n = {sig_b[MAN_W-2:0], 1'b0};
          exp_b_n = exp_b - EXP_W'(1);
        end
        if (sig_a_n[MAN_W-1] && sig_b_n[MAN_W-1]) begin
          state_n = ST_EXP;
        end
      end
      ST_EXP: begin
        exp_out_n = exp_a + exp_b - EXP_W'(BIAS);
        frac_a_n  = sig_a;
        frac_b_n  = sig_b;
        state_n   = ST_DONE;
      end
      ST_DONE: begin
        // First DONE cycle raises out_valid; handshake returns to IDLE.
        if (out_valid && out_ready) begin
          out_valid_n = 1'b0;
          state_n     = ST_IDLE;
        end else begin
          out_valid_n = 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    in_ready_n = (state_n == ST_IDLE);
  end

endmodule
